spi_frame_rx: RTL and testbench

SPI_FRAME_RX -- requirements
Module: spi_frame_rx

---
 rtl/spi_frame_rx.sv | 205 ++++++++++++++++++++
 tb/tb_spi_frame_rx.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_rx.sv
// SPI audio frame receiver: synchronises a slow SPI link into the clk_25mhz domain,
// assembles DATA_W-bit words tagged with a channel index and queues them in a FWFT FIFO.
module spi_frame_rx #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned CHANNELS   = 2,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned MSB_FIRST  = 1,
  localparam int unsigned CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int unsigned LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk_25mhz,
  input  logic              reset,
  input  logic              com_sclk_in,
  input  logic              com_mosi_in,
  input  logic              com_active,
  output logic [DATA_W-1:0] out_data,
  output logic [CH_W-1:0]   out_channel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LVL_W-1:0]  fifo_level,
  output logic              frame_done,
  output logic              frame_error,
  output logic              overflow,
  input  logic              clr_overflow
);

  localparam int unsigned BIT_W = $clog2(DATA_W);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned ENT_W = CH_W + DATA_W;
  localparam logic [BIT_W-1:0] LastBit = BIT_W'(DATA_W - 1);
  localparam logic [CH_W-1:0]  LastCh  = CH_W'(CHANNELS - 1);
  localparam logic [LVL_W-1:0] FullLvl = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StRecv, StWaitIdle} state_e;

  logic [2:0] sclk_sync_q, sclk_sync_d;
  logic [2:0] act_sync_q, act_sync_d;
  logic [1:0] mosi_sync_q, mosi_sync_d;

  state_e            state_q, state_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [CH_W-1:0]   ch_cnt_q, ch_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              got_word_q, got_word_d;
  logic [1:0]        settle_q, settle_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [ENT_W-1:0]  mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [ENT_W-1:0]  last_q, last_d;
  logic              overflow_q, overflow_d;

  logic              sclk_rise, act_rise, act_fall, act_s, mosi_s;
  logic [DATA_W-1:0] shift_next;
  logic [ENT_W-1:0]  push_word, head;
  logic              push, pop, full, empty, wr_en;

  assign sclk_sync_d = {sclk_sync_q[1:0], com_sclk_in};
  assign act_sync_d  = {act_sync_q[1:0], com_active};
  assign mosi_sync_d = {mosi_sync_q[0], com_mosi_in};

  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign act_rise  = act_sync_q[1] & ~act_sync_q[2];
  assign act_fall  = ~act_sync_q[1] & act_sync_q[2];
  assign act_s     = act_sync_q[1];
  assign mosi_s    = mosi_sync_q[1];

  assign shift_next = (MSB_FIRST != 0) ? {shift_q[DATA_W-2:0], mosi_s}
                                       : {mosi_s, shift_q[DATA_W-1:1]};
  assign push_word  = {ch_cnt_q, shift_next};

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    ch_cnt_d   = ch_cnt_q;
    shift_d    = shift_q;
    got_word_d = got_word_q;
    settle_d   = settle_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    push       = 1'b0;
    unique case (state_q)
      StWaitIdle: begin
        // The synchronisers restart from 0 after reset; wait until they carry the real
        // com_active level so a frame still in progress is not mistaken for a new one.
        if (settle_q != 2'd3) begin
          settle_d = settle_q + 2'd1;
        end else if (!act_s) begin
          state_d = StIdle;
        end
      end
      StIdle: begin
        if (act_rise) begin
          state_d    = StRecv;
          bit_cnt_d  = '0;
          ch_cnt_d   = '0;
          got_word_d = 1'b0;
        end
      end
      StRecv: begin
        if (act_fall) begin
          state_d = StIdle;
          if (bit_cnt_q == '0 && ch_cnt_q == '0 && got_word_q) begin
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else if (sclk_rise) begin
          shift_d = shift_next;
          if (bit_cnt_q == LastBit) begin
            push       = 1'b1;
            bit_cnt_d  = '0;
            ch_cnt_d   = (ch_cnt_q == LastCh) ? '0 : ch_cnt_q + CH_W'(1);
            got_word_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      default: state_d = StWaitIdle;
    endcase
  end

  assign empty = (level_q == '0);
  assign full  = (level_q == FullLvl);
  assign pop   = ~empty & out_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign wr_en = push & (~full | pop);

  always_comb begin
    wr_ptr_d   = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    last_d     = pop ? mem_q[rd_ptr_q] : last_q;
    level_d    = level_q;
    case ({wr_en, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    overflow_d = overflow_q;
    if (push && full && !pop) begin
      overflow_d = 1'b1;
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk_25mhz) begin
    if (!reset) begin
      sclk_sync_q <= '0;
      act_sync_q  <= '0;
      mosi_sync_q <= '0;
      state_q     <= StWaitIdle;
      bit_cnt_q   <= '0;
      ch_cnt_q    <= '0;
      shift_q     <= '0;
      got_word_q  <= 1'b0;
      settle_q    <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      last_q      <= '0;
      overflow_q  <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      act_sync_q  <= act_sync_d;
      mosi_sync_q <= mosi_sync_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      ch_cnt_q    <= ch_cnt_d;
      shift_q     <= shift_d;
      got_word_q  <= got_word_d;
      settle_q    <= settle_d;
      done_q      <= done_d;
      err_q       <= err_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      last_q      <= last_d;
      overflow_q  <= overflow_d;
    end
  end

  always_ff @(posedge clk_25mhz) begin
    if (reset && wr_en) begin
      mem_q[wr_ptr_q] <= push_word;
    end
  end

  // While empty the outputs keep showing the most recently popped entry.
  assign head        = empty ? last_q : mem_q[rd_ptr_q];
  assign out_data    = head[DATA_W-1:0];
  assign out_channel = head[ENT_W-1:DATA_W];
  assign out_valid   = ~empty;
  assign fifo_level  = level_q;
  assign frame_done  = done_q;
  assign frame_error = err_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_spi_frame_rx.sv
// Directed bench for spi_frame_rx: stereo MSB-first instance plus a mono 24-bit LSB-first one.
module tb_spi_frame_rx;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic        reset, sclk, mosi, active, active2, out_ready, out_ready2, clr_ovf;
  logic [15:0] out_data;
  logic        out_channel, out_valid, frame_done, frame_error, overflow;
  logic [3:0]  fifo_level;
  logic [23:0] out_data2;
  logic        out_channel2, out_valid2, frame_done2, frame_error2, overflow2;
  logic [3:0]  fifo_level2;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0, err_cnt = 0, done2_cnt = 0;
  logic [15:0] pop_data[$];
  logic        pop_ch[$];

  spi_frame_rx dut (
    .clk_25mhz(clk), .reset(reset), .com_sclk_in(sclk), .com_mosi_in(mosi),
    .com_active(active), .out_data(out_data), .out_channel(out_channel),
    .out_valid(out_valid), .out_ready(out_ready), .fifo_level(fifo_level),
    .frame_done(frame_done), .frame_error(frame_error), .overflow(overflow),
    .clr_overflow(clr_ovf)
  );

  spi_frame_rx #(.DATA_W(24), .CHANNELS(1), .FIFO_DEPTH(8), .MSB_FIRST(0)) dut24 (
    .clk_25mhz(clk), .reset(reset), .com_sclk_in(sclk), .com_mosi_in(mosi),
    .com_active(active2), .out_data(out_data2), .out_channel(out_channel2),
    .out_valid(out_valid2), .out_ready(out_ready2), .fifo_level(fifo_level2),
    .frame_done(frame_done2), .frame_error(frame_error2), .overflow(overflow2),
    .clr_overflow(1'b0)
  );

  // Inputs change on negedge; this samples just after so it sees the settled values.
  always @(negedge clk) begin
    #1;
    if (frame_done) done_cnt++;
    if (frame_error) err_cnt++;
    if (frame_done2) done2_cnt++;
    if (out_valid && out_ready) begin
      pop_data.push_back(out_data);
      pop_ch.push_back(out_channel);
    end
  end

  task automatic spi_bit(input logic b, input bit pop_on_push);
    mosi = b;
    sclk = 1'b0;
    repeat (4) @(negedge clk);
    sclk = 1'b1;
    if (pop_on_push) begin
      // The push lands on the third posedge after SCLK rises; pop on exactly that edge.
      repeat (2) @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      @(negedge clk);
    end else begin
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int nbits, input bit msb, input bit pop);
    for (int i = 0; i < nbits; i++) begin
      spi_bit(msb ? w[nbits-1-i] : w[i], pop && (i == nbits - 1));
    end
  endtask

  task automatic start_frame(input bit second);
    if (second) active2 = 1'b1;
    else active = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic end_frame();
    sclk = 1'b0;
    repeat (4) @(negedge clk);
    active  = 1'b0;
    active2 = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || fifo_level !== 4'd0) begin
      errors++;
      $display("FAIL reset_fifo: valid=%b level=%0d want 0/0", out_valid, fifo_level);
    end
    checks++;
    if (out_data !== 16'h0 || out_channel !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: data=%h ch=%b want 0/0", out_data, out_channel);
    end
    checks++;
    if (frame_done !== 1'b0 || frame_error !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: done=%b err=%b ovf=%b want 0", frame_done, frame_error,
               overflow);
    end
    reset = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_stereo();
    int base = pop_data.size();
    int d0 = done_cnt;
    int e0 = err_cnt;
    out_ready = 1'b1;
    start_frame(0);
    send_word(16'hC0DE, 16, 1, 0);
    send_word(16'hBEEF, 16, 1, 0);
    end_frame();
    checks++;
    if (pop_data.size() - base !== 2) begin
      errors++;
      $display("FAIL stereo_count: got %0d words want 2", pop_data.size() - base);
    end else begin
      checks++;
      if (pop_data[base] !== 16'hC0DE || pop_ch[base] !== 1'b0) begin
        errors++;
        $display("FAIL stereo_w0: got %h ch%b want c0de ch0", pop_data[base], pop_ch[base]);
      end
      checks++;
      if (pop_data[base+1] !== 16'hBEEF || pop_ch[base+1] !== 1'b1) begin
        errors++;
        $display("FAIL stereo_w1: got %h ch%b want beef ch1", pop_data[base+1],
                 pop_ch[base+1]);
      end
    end
    checks++;
    if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin
      errors++;
      $display("FAIL stereo_pulses: done=%0d err=%0d want 1/0", done_cnt - d0, err_cnt - e0);
    end
  endtask

  task automatic test_short_frame();
    int base = pop_data.size();
    int d0 = done_cnt;
    int e0 = err_cnt;
    out_ready = 1'b1;
    start_frame(0);
    send_word(16'h1234, 16, 1, 0);
    send_word(32'h55, 7, 1, 0);
    end_frame();
    checks++;
    if (pop_data.size() - base !== 1) begin
      errors++;
      $display("FAIL short_count: got %0d words want 1", pop_data.size() - base);
    end else begin
      checks++;
      if (pop_data[base] !== 16'h1234 || pop_ch[base] !== 1'b0) begin
        errors++;
        $display("FAIL short_word: got %h ch%b want 1234 ch0", pop_data[base], pop_ch[base]);
      end
    end
    checks++;
    if (done_cnt - d0 !== 0 || err_cnt - e0 !== 1) begin
      errors++;
      $display("FAIL short_pulses: done=%0d err=%0d want 0/1", done_cnt - d0, err_cnt - e0);
    end
    base = pop_data.size();
    start_frame(0);
    send_word(16'h5555, 16, 1, 0);
    send_word(16'hAAAA, 16, 1, 0);
    end_frame();
    checks++;
    if (pop_data.size() - base !== 2) begin
      errors++;
      $display("FAIL short_next_count: got %0d words want 2", pop_data.size() - base);
    end else begin
      checks++;
      if (pop_data[base] !== 16'h5555 || pop_ch[base] !== 1'b0 || pop_ch[base+1] !== 1'b1) begin
        errors++;
        $display("FAIL short_next_ch: got %h ch%b,%b want 5555 ch0,ch1", pop_data[base],
                 pop_ch[base], pop_ch[base+1]);
      end
    end
  endtask

  task automatic test_overflow();
    int base;
    out_ready = 1'b0;
    for (int f = 0; f < 5; f++) begin
      start_frame(0);
      send_word(32'hA000 + 2 * f, 16, 1, 0);
      send_word(32'hA001 + 2 * f, 16, 1, 0);
      end_frame();
    end
    checks++;
    if (fifo_level !== 4'd8 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_full: level=%0d ovf=%b want 8/1", fifo_level, overflow);
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'hA000 || out_channel !== 1'b0) begin
      errors++;
      $display("FAIL ovf_head: valid=%b data=%h ch=%b want 1/a000/0", out_valid, out_data,
               out_channel);
    end
    base = pop_data.size();
    out_ready = 1'b1;
    repeat (12) @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (pop_data.size() - base !== 8) begin
      errors++;
      $display("FAIL ovf_drain_count: got %0d want 8", pop_data.size() - base);
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (pop_data[base+i] !== 16'(16'hA000 + i) || pop_ch[base+i] !== 1'(i % 2)) begin
          errors++;
          $display("FAIL ovf_drain_w%0d: got %h ch%b want %h ch%0d", i, pop_data[base+i],
                   pop_ch[base+i], 16'hA000 + i, i % 2);
        end
      end
    end
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'hA007 || out_channel !== 1'b1) begin
      errors++;
      $display("FAIL empty_hold: valid=%b data=%h ch=%b want 0/a007/1", out_valid, out_data,
               out_channel);
    end
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: got %b want 1", overflow);
    end
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: got %b want 0", overflow);
    end
  endtask

  task automatic test_full_push_pop();
    out_ready = 1'b0;
    for (int f = 0; f < 4; f++) begin
      start_frame(0);
      send_word(32'hB000 + 2 * f, 16, 1, 0);
      send_word(32'hB001 + 2 * f, 16, 1, 0);
      end_frame();
    end
    start_frame(0);
    send_word(32'hB008, 16, 1, 1);
    send_word(32'hB009, 16, 1, 1);
    end_frame();
    checks++;
    if (fifo_level !== 4'd8 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL fullpp_level: level=%0d ovf=%b want 8/0", fifo_level, overflow);
    end
    checks++;
    if (out_data !== 16'hB002) begin
      errors++;
      $display("FAIL fullpp_head: got %h want b002", out_data);
    end
    out_ready = 1'b1;
    repeat (12) @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_midframe();
    int base, d0, e0;
    out_ready = 1'b0;
    start_frame(0);
    send_word(16'hC000, 16, 1, 0);
    send_word(16'hC001, 16, 1, 0);
    end_frame();
    start_frame(0);
    send_word(32'hD0, 8, 1, 0);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    checks++;
    if (fifo_level !== 4'd0 || out_valid !== 1'b0 || out_data !== 16'h0) begin
      errors++;
      $display("FAIL midrst_out: level=%0d valid=%b data=%h want 0/0/0", fifo_level, out_valid,
               out_data);
    end
    d0 = done_cnt;
    e0 = err_cnt;
    send_word(32'h0D, 8, 1, 0);
    send_word(16'h1111, 16, 1, 0);
    end_frame();
    checks++;
    if (fifo_level !== 4'd0 || done_cnt - d0 !== 0 || err_cnt - e0 !== 0) begin
      errors++;
      $display("FAIL midrst_ignore: level=%0d done=%0d err=%0d want 0/0/0", fifo_level,
               done_cnt - d0, err_cnt - e0);
    end
    base = pop_data.size();
    d0 = done_cnt;
    out_ready = 1'b1;
    start_frame(0);
    send_word(16'h1357, 16, 1, 0);
    send_word(16'h2468, 16, 1, 0);
    end_frame();
    checks++;
    if (pop_data.size() - base !== 2 || done_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL midrst_next: words=%0d done=%0d want 2/1", pop_data.size() - base,
               done_cnt - d0);
    end else begin
      checks++;
      if (pop_data[base] !== 16'h1357 || pop_data[base+1] !== 16'h2468 || pop_ch[base] !== 1'b0)
      begin
        errors++;
        $display("FAIL midrst_words: got %h,%h ch%b want 1357,2468 ch0", pop_data[base],
                 pop_data[base+1], pop_ch[base]);
      end
    end
  endtask

  task automatic test_lsb24();
    int d0 = done2_cnt;
    out_ready2 = 1'b0;
    start_frame(1);
    send_word(32'hA5C3F0, 24, 0, 0);
    end_frame();
    checks++;
    if (out_valid2 !== 1'b1 || out_data2 !== 24'hA5C3F0 || out_channel2 !== 1'b0) begin
      errors++;
      $display("FAIL lsb24_word: valid=%b data=%h ch=%b want 1/a5c3f0/0", out_valid2,
               out_data2, out_channel2);
    end
    checks++;
    if (done2_cnt - d0 !== 1 || fifo_level2 !== 4'd1) begin
      errors++;
      $display("FAIL lsb24_done: done=%0d level=%0d want 1/1", done2_cnt - d0, fifo_level2);
    end
    checks++;
    if (fifo_level !== 4'd0) begin
      errors++;
      $display("FAIL idle_ignore: main level=%0d want 0", fifo_level);
    end
  endtask

  initial begin
    reset      = 1'b0;
    sclk       = 1'b0;
    mosi       = 1'b0;
    active     = 1'b0;
    active2    = 1'b0;
    out_ready  = 1'b0;
    out_ready2 = 1'b0;
    clr_ovf    = 1'b0;
    @(negedge clk);
    test_reset();
    test_stereo();
    test_short_frame();
    test_overflow();
    test_full_push_pop();
    test_reset_midframe();
    test_lsb24();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
